perceptron_train_seq: RTL and testbench
=======================================

// Module: perceptron_train_seq
// PURPOSE
//  Parametrised training sequencer for the single-layer perceptron/Adaline datapath, with N_FEAT inputs.
//  It walks the sample memory, drives the MAC and weight-update strobes one feature per cycle, and tracks
//  per-epoch change internally. It stops on convergence, on an epoch cap, or on abort.
// PARAMETERS
//  N_FEAT      2    number of input features/weights (>=1); bias handled as extra slot
//  IDX_W       2    width of feature index, must satisfy 2**IDX_W >= N_FEAT
//  ADDR_W      8    sample-memory address width
//  N_SAMPLES   200  samples per epoch (1..2**ADDR_W)
//  EPOCH_W     8    epoch counter width
//  MAX_EPOCHS  0    epoch cap; 0 = unlimited
// PORTS
//  clk        in   1        single clock, rising edge
//  rst_n      in   1        asynchronous, active-low reset
//  start      in   1        begin training; sampled only in IDLE
//  abort      in   1        synchronous abort; any state -> IDLE next edge
//  compare    in   1        datapath: 1 = sample misclassified, update required (valid in EVAL)
//  ready      out  1        1 while in IDLE
//  done       out  1        1-cycle pulse on leaving DONE
//  converged  out  1        held: last run ended with an epoch of zero updates
//  timeout    out  1        held: last run hit MAX_EPOCHS
//  epoch_cnt  out  EPOCH_W  completed epochs of current/last run
//  rd_en      out  1        sample-memory read strobe; data valid the following cycle
//  rd_addr    out  ADDR_W   sample index
//  init       out  1        clear weights, bias and yin
//  ld_x       out  1        latch x[0..N_FEAT-1] and t from memory data
//  clr_yin    out  1        clear yin accumulator
//  mac_en     out  1        yin += w[idx]*x[idx]
//  add_bias   out  1        yin += b
//  upd_en     out  1        w[idx] += alpha*t*x[idx]
//  upd_bias   out  1        b += alpha*t
//  ld_alphat  out  1        latch alpha*t product
//  idx        out  IDX_W    feature index for mac_en/upd_en, else 0
// BEHAVIOUR
//  Reset: state IDLE, ready=1, all other outputs 0, sample/epoch/feature counters 0, changed=0.
//  All outputs are registered or decoded from the state register only (Moore); no input-to-output paths.
//  States and transitions:
//   IDLE   : start -> INIT. Otherwise stay in IDLE.
//   INIT   : init=1; clears converged, timeout, epoch_cnt, sample_idx and changed -> FETCH.
//   FETCH  : rd_en=1, rd_addr=sample_idx -> LATCH.
//   LATCH  : ld_x=1, clr_yin=1, feat=0 -> MAC.
//   MAC    : mac_en=1, idx=feat; feat++ each cycle; after idx=N_FEAT-1 -> BIAS (exactly N_FEAT cycles).
//   BIAS   : add_bias=1 -> EVAL.
//   EVAL   : sample compare. If compare=1: ld_alphat=1, changed<=1, feat=0 -> UPD. Otherwise -> NEXT.
//   UPD    : upd_en=1, idx=feat for N_FEAT cycles -> UPDB.
//   UPDB   : upd_bias=1 -> NEXT.
//   NEXT   : if sample_idx==N_SAMPLES-1: sample_idx<=0 -> EPOCH. Otherwise sample_idx++ -> FETCH.
//   EPOCH  : epoch_cnt++ (saturating).
//            If changed==0: converged<=1 -> DONE.
//            Else if MAX_EPOCHS!=0 and new epoch_cnt==MAX_EPOCHS: timeout<=1 -> DONE.
//            Else: changed<=0 -> FETCH.
//   DONE   : done=1 for one cycle -> IDLE.
//  Latency per sample: N_FEAT+5 cycles without an update; 2*N_FEAT+6 cycles with an update.
//  Convergence takes priority over timeout when both would apply in the same EPOCH.
//  abort has priority over all transitions: next state IDLE, done not pulsed, converged/timeout unchanged,
//   epoch_cnt holds its value. Datapath registers are not cleared by abort.
//  start asserted outside IDLE is ignored. start held high restarts the sequencer after DONE->IDLE.
//  rst_n asserted mid-run: immediate return to the reset state; no done pulse.
//  The epoch counter saturates at all-ones; with MAX_EPOCHS=0 training continues until convergence or abort.
// TESTING
//  1) N_FEAT=2, N_SAMPLES=4, compare=0 always, pulse start -> INIT, 1 epoch of 4*7 cycles, converged=1,
//     epoch_cnt=1, done pulse; run is 32 cycles from start.
//  2) N_FEAT=3, compare=1 on sample 2 of epoch 0 only -> upd_en idx 0,1,2 then upd_bias; epoch 1 clean;
//     converged=1, epoch_cnt=2.
//  3) MAX_EPOCHS=3, compare=1 on every sample -> timeout=1, converged=0, epoch_cnt=3, done pulse once.
//  4) Abort asserted in the 2nd MAC cycle -> next cycle IDLE, ready=1, no done pulse, mac_en=0.
//  5) rst_n low during UPD -> all outputs 0 and ready=1 asynchronously; a later start runs cleanly from INIT.
//  6) start pulsed during EVAL and held high through DONE -> the mid-run start is ignored; a second run
//     begins after IDLE, and INIT clears converged.

Source files
------------

// File: rtl/perceptron_train_seq.sv
// rtl/perceptron_train_seq.sv - training sequencer for a single-layer perceptron/Adaline datapath
module perceptron_train_seq #(
    parameter int N_FEAT     = 2,
    parameter int IDX_W      = 2,
    parameter int ADDR_W     = 8,
    parameter int N_SAMPLES  = 200,
    parameter int EPOCH_W    = 8,
    parameter int MAX_EPOCHS = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic               compare,
    output logic               ready,
    output logic               done,
    output logic               converged,
    output logic               timeout,
    output logic [EPOCH_W-1:0] epoch_cnt,
    output logic               rd_en,
    output logic [ADDR_W-1:0]  rd_addr,
    output logic               init,
    output logic               ld_x,
    output logic               clr_yin,
    output logic               mac_en,
    output logic               add_bias,
    output logic               upd_en,
    output logic               upd_bias,
    output logic               ld_alphat,
    output logic [IDX_W-1:0]   idx
);

    localparam logic [IDX_W-1:0]   LAST_FEAT   = IDX_W'(N_FEAT - 1);
    localparam logic [ADDR_W-1:0]  LAST_SAMPLE = ADDR_W'(N_SAMPLES - 1);
    localparam logic [EPOCH_W-1:0] EPOCH_CAP   = EPOCH_W'(MAX_EPOCHS);

    typedef enum logic [3:0] {
        S_IDLE, S_INIT, S_FETCH, S_LATCH, S_MAC, S_BIAS,
        S_EVAL, S_UPD, S_UPDB, S_NEXT, S_EPOCH, S_DONE
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [IDX_W-1:0]   feat;
    logic [ADDR_W-1:0]  sample_idx;
    logic               changed;
    logic [EPOCH_W-1:0] epoch_inc;
    logic               cap_hit;

    assign epoch_inc = (epoch_cnt == {EPOCH_W{1'b1}}) ? epoch_cnt : epoch_cnt + EPOCH_W'(1);
    assign cap_hit   = (MAX_EPOCHS != 0) && (epoch_inc == EPOCH_CAP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start) state_next = S_INIT;
                S_INIT:  state_next = S_FETCH;
                S_FETCH: state_next = S_LATCH;
                S_LATCH: state_next = S_MAC;
                S_MAC:   if (feat == LAST_FEAT) state_next = S_BIAS;
                S_BIAS:  state_next = S_EVAL;
                S_EVAL:  state_next = compare ? S_UPD : S_NEXT;
                S_UPD:   if (feat == LAST_FEAT) state_next = S_UPDB;
                S_UPDB:  state_next = S_NEXT;
                S_NEXT:  state_next = (sample_idx == LAST_SAMPLE) ? S_EPOCH : S_FETCH;
                S_EPOCH: state_next = (!changed || cap_hit) ? S_DONE : S_FETCH;
                S_DONE:  state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    // Counters and run status; abort freezes them so a stopped run stays inspectable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            feat       <= '0;
            sample_idx <= '0;
            changed    <= 1'b0;
            epoch_cnt  <= '0;
            converged  <= 1'b0;
            timeout    <= 1'b0;
        end else if (!abort) begin
            case (state)
                S_INIT: begin
                    converged  <= 1'b0;
                    timeout    <= 1'b0;
                    epoch_cnt  <= '0;
                    sample_idx <= '0;
                    changed    <= 1'b0;
                end
                S_LATCH: feat <= '0;
                S_MAC:   feat <= feat + IDX_W'(1);
                S_EVAL: begin
                    if (compare) begin
                        changed <= 1'b1;
                        feat    <= '0;
                    end
                end
                S_UPD:   feat <= feat + IDX_W'(1);
                S_NEXT:  sample_idx <= (sample_idx == LAST_SAMPLE) ? '0 : sample_idx + ADDR_W'(1);
                S_EPOCH: begin
                    epoch_cnt <= epoch_inc;
                    if (!changed) begin
                        converged <= 1'b1;
                    end else if (cap_hit) begin
                        timeout <= 1'b1;
                    end else begin
                        changed <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // alpha*t is latched on every EVAL so the strobe depends on state alone; unused when no update follows.
    always_comb begin
        ready     = (state == S_IDLE);
        done      = (state == S_DONE);
        init      = (state == S_INIT);
        rd_en     = (state == S_FETCH);
        rd_addr   = (state == S_FETCH) ? sample_idx : '0;
        ld_x      = (state == S_LATCH);
        clr_yin   = (state == S_LATCH);
        mac_en    = (state == S_MAC);
        add_bias  = (state == S_BIAS);
        ld_alphat = (state == S_EVAL);
        upd_en    = (state == S_UPD);
        upd_bias  = (state == S_UPDB);
        idx       = (state == S_MAC || state == S_UPD) ? feat : '0;
    end

endmodule

// File: tb/tb_perceptron_train_seq.sv
// tb/tb_perceptron_train_seq.sv - randomized cycle-trace bench for perceptron_train_seq
module tb_perceptron_train_seq;

    localparam int N_FEAT     = 3;
    localparam int IDX_W      = 2;
    localparam int ADDR_W     = 3;
    localparam int N_SAMPLES  = 5;
    localparam int EPOCH_W    = 4;
    localparam int MAX_EPOCHS = 3;

    logic clk = 1'b0;
    logic rst_n, start, abort, compare;
    logic ready, done, converged, timeout, rd_en, init, ld_x, clr_yin;
    logic mac_en, add_bias, upd_en, upd_bias, ld_alphat;
    logic [EPOCH_W-1:0] epoch_cnt;
    logic [ADDR_W-1:0]  rd_addr;
    logic [IDX_W-1:0]   idx;

    always #5 clk = ~clk;

    perceptron_train_seq #(
        .N_FEAT(N_FEAT), .IDX_W(IDX_W), .ADDR_W(ADDR_W),
        .N_SAMPLES(N_SAMPLES), .EPOCH_W(EPOCH_W), .MAX_EPOCHS(MAX_EPOCHS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .compare(compare),
        .ready(ready), .done(done), .converged(converged), .timeout(timeout),
        .epoch_cnt(epoch_cnt), .rd_en(rd_en), .rd_addr(rd_addr), .init(init),
        .ld_x(ld_x), .clr_yin(clr_yin), .mac_en(mac_en), .add_bias(add_bias),
        .upd_en(upd_en), .upd_bias(upd_bias), .ld_alphat(ld_alphat), .idx(idx)
    );

    typedef struct packed {
        logic ready, done, init, rd_en, ld_x, clr_yin, mac_en, add_bias;
        logic upd_en, upd_bias, ld_alphat, conv, tmo;
        logic [IDX_W-1:0]   idx;
        logic [ADDR_W-1:0]  addr;
        logic [EPOCH_W-1:0] ep;
    } exp_t;

    typedef struct {
        exp_t e;
        logic start;
        logic cmp;
        logic abort;
    } cyc_t;

    logic [31:0] obs;
    assign obs = 32'({ready, done, init, rd_en, ld_x, clr_yin, mac_en, add_bias,
                      upd_en, upd_bias, ld_alphat, converged, timeout, idx, rd_addr, epoch_cnt});

    cyc_t               q[$];
    logic               m_conv = 1'b0;
    logic               m_to = 1'b0;
    logic [EPOCH_W-1:0] m_ep = '0;
    int                 checks = 0;
    int                 errors = 0;
    int                 cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic rb();
        return $urandom_range(0, 1) != 0;
    endfunction

    function automatic exp_t base();
        exp_t e = '0;
        e.conv = m_conv;
        e.tmo  = m_to;
        e.ep   = m_ep;
        return e;
    endfunction

    task automatic push(input exp_t e, input logic st, input logic c);
        cyc_t t;
        t.e = e; t.start = st; t.cmp = c; t.abort = 1'b0;
        q.push_back(t);
    endtask

    function automatic logic plan(input int mode, input int ep);
        case (mode)
            0:       return 1'b0;
            1:       return (ep == 0) ? rb() : 1'b0;
            2:       return 1'b1;
            default: return $urandom_range(0, 2) == 0;
        endcase
    endfunction

    task automatic idle_rec(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e = base(); e.ready = 1'b1;
            push(e, 1'b0, rb());
        end
    endtask

    // Expected cycle trace of one full run, from the IDLE cycle that sees start through DONE.
    task automatic build_run(input int mode);
        exp_t e;
        logic chg, c, fin;
        int   ep;
        e = base(); e.ready = 1'b1; push(e, 1'b1, rb());
        e = base(); e.init = 1'b1;  push(e, rb(), rb());
        m_conv = 1'b0; m_to = 1'b0; m_ep = '0;
        ep = 0; fin = 1'b0;
        while (!fin) begin
            chg = 1'b0;
            for (int s = 0; s < N_SAMPLES; s++) begin
                e = base(); e.rd_en = 1'b1; e.addr = ADDR_W'(s); push(e, rb(), rb());
                e = base(); e.ld_x = 1'b1; e.clr_yin = 1'b1;    push(e, rb(), rb());
                for (int f = 0; f < N_FEAT; f++) begin
                    e = base(); e.mac_en = 1'b1; e.idx = IDX_W'(f); push(e, rb(), rb());
                end
                e = base(); e.add_bias = 1'b1; push(e, rb(), rb());
                c = plan(mode, ep);
                e = base(); e.ld_alphat = 1'b1; push(e, rb(), c);
                if (c) begin
                    chg = 1'b1;
                    for (int f = 0; f < N_FEAT; f++) begin
                        e = base(); e.upd_en = 1'b1; e.idx = IDX_W'(f); push(e, rb(), rb());
                    end
                    e = base(); e.upd_bias = 1'b1; push(e, rb(), rb());
                end
                e = base(); push(e, rb(), rb());
            end
            e = base(); push(e, rb(), rb());
            if (m_ep != '1) m_ep = m_ep + 1'b1;
            if (!chg) begin
                m_conv = 1'b1; fin = 1'b1;
            end else if (MAX_EPOCHS != 0 && m_ep == EPOCH_W'(MAX_EPOCHS)) begin
                m_to = 1'b1; fin = 1'b1;
            end
            ep++;
        end
        e = base(); e.done = 1'b1; push(e, rb(), rb());
    endtask

    task automatic build_abort(input int mode, input int k_fixed);
        int   b;
        int   k;
        cyc_t t;
        b = q.size();
        build_run(mode);
        k = (k_fixed > 0) ? k_fixed : int'($urandom_range(1, q.size() - b - 1));
        while (q.size() > b + k + 1) void'(q.pop_back());
        t = q[b+k]; t.abort = 1'b1; q[b+k] = t;
        m_conv = t.e.conv; m_to = t.e.tmo; m_ep = t.e.ep;
    endtask

    task automatic play();
        for (int i = 0; i < q.size(); i++) begin
            @(negedge clk);
            check($sformatf("cyc%0d", cyc), obs, 32'(q[i].e));
            start   = q[i].start;
            compare = q[i].cmp;
            abort   = q[i].abort;
            cyc++;
        end
        q.delete();
    endtask

    initial begin
        exp_t r;
        int   b;
        int   k;
        cyc_t t;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; compare = 1'b0;
        r = '0; r.ready = 1'b1;
        repeat (2) @(negedge clk);
        check("reset", obs, 32'(r));
        rst_n = 1'b1;
        idle_rec(2); play();

        build_run(0); idle_rec(1); play();
        build_run(1); play();
        build_run(2); idle_rec(1); play();

        build_abort(3, 5); idle_rec(2); play();

        // start pulsed/held from the first EVAL onward; DONE->IDLE must restart, INIT clears converged
        b = q.size();
        build_run(1);
        k = b;
        while (!q[k].e.ld_alphat) k++;
        for (int i = k; i < q.size(); i++) begin
            t = q[i]; t.start = 1'b1; q[i] = t;
        end
        build_run(2); idle_rec(1); play();

        // asynchronous reset in the first UPD cycle
        build_run(2);
        k = 0;
        while (!q[k].e.upd_en) k++;
        while (q.size() > k + 1) void'(q.pop_back());
        play();
        #2 rst_n = 1'b0;
        #1 check("rst_async", obs, 32'(r));
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_conv = 1'b0; m_to = 1'b0; m_ep = '0;
        build_run(3); idle_rec(1); play();

        for (int n = 0; n < 14; n++) begin
            if ($urandom_range(0, 2) == 0) build_abort(3, 0);
            else build_run(int'($urandom_range(0, 3)));
            if (rb()) idle_rec(int'($urandom_range(1, 3)));
        end
        idle_rec(1); play();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
